// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled digit counter: digit/segment widths,
// active-low seven-segment patterns (bit 0 = a .. bit 6 = g), radix selection
// and the nibble-to-segment helper used by the per-digit decoder.
package prescaled_counter_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;

   // Segment patterns, written g..a, low = lit
   localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

   // Digit radix: decimal when bcd is nonzero, hexadecimal otherwise
   function automatic int unsigned radix_of(input int unsigned bcd);
      return (bcd != 0) ? 10 : 16;
   endfunction

   // Nibble to active-low segment pattern
   function automatic logic [SEG_W-1:0] seg7_encode(input logic [DIGIT_W-1:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'h0:    s = SEG_0;
         4'h1:    s = SEG_1;
         4'h2:    s = SEG_2;
         4'h3:    s = SEG_3;
         4'h4:    s = SEG_4;
         4'h5:    s = SEG_5;
         4'h6:    s = SEG_6;
         4'h7:    s = SEG_7;
         4'h8:    s = SEG_8;
         4'h9:    s = SEG_9;
         4'hA:    s = SEG_A;
         4'hB:    s = SEG_B;
         4'hC:    s = SEG_C;
         4'hD:    s = SEG_D;
         4'hE:    s = SEG_E;
         default: s = SEG_F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/digit_seg7_decode.sv
// Single-digit 4-bit to active-low seven-segment decoder (combinational).
//   digit_i : nibble to display
//   seg_o   : segments, bit 0 = a .. bit 6 = g, low = lit
module digit_seg7_decode
   import prescaled_counter_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [SEG_W-1:0]   seg_o
);

   assign seg_o = seg7_encode(digit_i);

endmodule

// File: rtl/prescaled_digit_counter.sv
// Multi-digit up/down counter (BCD or hex digits) advanced once every
// TICK_DIV enabled clocks, with parallel load and seven-segment outputs.
//   clk      : clock, rising edge
//   Resetn   : asynchronous active-low reset
//   en       : enable for prescaler and counter
//   up       : 1 = count up, 0 = count down
//   load     : synchronous load strobe (priority over en)
//   load_val : load value, digit 0 in [3:0]
//   count    : registered count, digit 0 in [3:0]
//   tick     : one-cycle pulse in the cycle a step is visible on count
//   wrap     : one-cycle pulse with tick on full-range roll-over
//   hex      : active-low segments per digit, digit 0 in [6:0]
module prescaled_digit_counter
   import prescaled_counter_pkg::*;
#(
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned BCD      = 1,
   parameter int unsigned TICK_DIV = 50000000
)(
   input  logic                       clk,
   input  logic                       Resetn,
   input  logic                       en,
   input  logic                       up,
   input  logic                       load,
   input  logic [DIGIT_W*DIGITS-1:0]  load_val,
   output logic [DIGIT_W*DIGITS-1:0]  count,
   output logic                       tick,
   output logic                       wrap,
   output logic [SEG_W*DIGITS-1:0]    hex
);

   localparam int unsigned CW         = DIGIT_W * DIGITS;
   localparam int unsigned RADIX      = radix_of(BCD);
   localparam logic [DIGIT_W-1:0] DIG_MAX = DIGIT_W'(RADIX - 1);
   localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;

   logic [CW-1:0] step_val;
   logic [CW-1:0] load_clamped;
   logic          roll_all;

   // Ripple +/-1 across digits; roll_all is the carry/borrow out of the top digit
   always_comb begin
      logic                carry;
      logic [DIGIT_W-1:0]  d;
      carry    = 1'b1;
      d        = '0;
      step_val = count_q;
      for (int k = 0; k < int'(DIGITS); k++) begin
         d = count_q[k*DIGIT_W +: DIGIT_W];
         if (carry) begin
            if (up) begin
               if (d >= DIG_MAX) begin
                  step_val[k*DIGIT_W +: DIGIT_W] = '0;
               end else begin
                  step_val[k*DIGIT_W +: DIGIT_W] = d + DIGIT_W'(1);
                  carry = 1'b0;
               end
            end else begin
               if (d == '0) begin
                  step_val[k*DIGIT_W +: DIGIT_W] = DIG_MAX;
               end else begin
                  step_val[k*DIGIT_W +: DIGIT_W] = d - DIGIT_W'(1);
                  carry = 1'b0;
               end
            end
         end
      end
      roll_all = carry;
   end

   // Decimal digits cannot hold values above 9, so clamp loaded digits
   always_comb begin
      logic [DIGIT_W-1:0] lv;
      lv           = '0;
      load_clamped = load_val;
      for (int k = 0; k < int'(DIGITS); k++) begin
         lv = load_val[k*DIGIT_W +: DIGIT_W];
         if ((BCD != 0) && (lv > 4'd9)) begin
            load_clamped[k*DIGIT_W +: DIGIT_W] = 4'd9;
         end
      end
   end

   // Next state: load beats enable; a step happens on the last prescaler count
   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = load_clamped;
         presc_d = '0;
      end else if (en) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = step_val;
            tick_d  = 1'b1;
            wrap_d  = roll_all;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge Resetn) begin
      if (!Resetn) begin
         count_q <= '0;
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign wrap  = wrap_q;

   // One segment decoder per digit, driven straight from the count register
   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
      digit_seg7_decode u_seg (
         .digit_i (count_q[g*DIGIT_W +: DIGIT_W]),
         .seg_o   (hex[g*SEG_W +: SEG_W])
      );
   end

endmodule

// File: doc/prescaled_digit_counter.md
PRESCALED_DIGIT_COUNTER -- requirements
Module: prescaled_digit_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of 4-bit digits in the counter, legal range 1..8.
REQ-002 Parameter BCD, default 1: 1 makes each digit count in radix 10, 0 makes each digit count in radix 16.
REQ-003 Parameter TICK_DIV, default 50000000: clk cycles per count step, legal range 1..2^32-1.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-006 Port Resetn, input, 1 bit: asynchronous active-low reset.
REQ-007 Port en, input, 1 bit: count enable; prescaler and counter hold while low.
REQ-008 Port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-009 Port load, input, 1 bit: synchronous parallel load strobe.
REQ-010 Port load_val, input, 4*DIGITS bits: value applied on load; digit 0 is in bits [3:0].
REQ-011 Port count, output, 4*DIGITS bits: registered counter value; digit 0 is in bits [3:0].
REQ-012 Port tick, output, 1 bit: registered one-cycle pulse, high in the cycle a step becomes visible on count.
REQ-013 Port wrap, output, 1 bit: registered one-cycle pulse on full-range roll-over in either direction.
REQ-014 Port hex, output, 7*DIGITS bits: active-low segments per digit; bit 0 = a through bit 6 = g; digit 0 is in bits [6:0].

Function
REQ-015 Prescaler behaviour while en=1 and load=0: counts 0..TICK_DIV-1 and wraps to 0; a step occurs on the edge where it equals TICK_DIV-1.
REQ-016 With TICK_DIV=1, a step occurs on every enabled edge and tick stays high continuously.
REQ-017 On a step: count changes by ±1 in the radix of REQ-002, carry/borrow ripples across all digits, and tick=1 for exactly the following cycle.
REQ-018 Digit boundaries: up counting rolls a digit from RADIX-1 to 0 with carry; down counting rolls a digit from 0 to RADIX-1 with borrow.
REQ-019 Full-range roll-over: all digits at max stepping up gives all zeros; all zeros stepping down gives all max; either case sets wrap=1 for the same cycle as tick.
REQ-020 With en=0: count and prescaler hold, and tick and wrap are 0.
REQ-021 load=1 has priority over step and en: count takes load_val, prescaler clears to 0, and tick and wrap are 0 next cycle.
REQ-022 BCD=1 load clamping: any load_val digit above 9 is stored as 9.
REQ-023 A change of up takes effect on the next step, with no glitch or extra step.
REQ-024 hex is combinational from count; patterns for 0-9 and A-F: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (g..a).
REQ-025 With BCD=1, count never holds a digit value above 9.

Reset
REQ-026 Resetn=0 immediately, without a clock edge, forces count=0, prescaler=0, tick=0, wrap=0, and every hex digit=1000000.
REQ-027 Reset asserted mid-step discards the pending step; after deassertion, counting resumes from 0 with a full TICK_DIV interval.

Structure
REQ-028 The segment pattern constants and the RADIX derivation from BCD live in the shared package prescaled_counter_pkg.
REQ-029 Per-digit 4-bit-to-7-segment decoding is the single sub-module digit_seg7_decode, instantiated DIGITS times.
REQ-030 The prescaler width is derived from TICK_DIV; no hard-coded width.

Verification
REQ-031 DIGITS=2, BCD=1, TICK_DIV=4; reset, then en=1, up=1 -> tick on every 4th cycle; count 0x00→0x01→0x02; hex[6:0]=1111001 after the first step.
REQ-032 load_val=0x99, then one up step -> count=0x00, wrap=1 and tick=1 for one cycle, hex=1000000 on both digits.
REQ-033 From count=0x00, up=0, one step -> count=0x99 and wrap=1 for one cycle.
REQ-034 load=1 with load_val=0x3C while en=0 -> count=0x39; the prescaler restarts, so the first step arrives 4 cycles after en rises.
REQ-035 Resetn pulled low between clock edges at count=0x57 -> count=0x00 before the next edge; no tick on deassertion.
REQ-036 BCD=0, DIGITS=2: count 0x0F stepping up -> 0x10; hex[13:7]=1111001 and hex[6:0]=1000000.
